pipeline_hazard_unit: RTL

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_match.sv | 24 ++
 rtl/pipeline_hazard_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default parameter values for the pipeline hazard unit.
package hazard_pkg;

    localparam int DEF_RW        = 5;
    localparam int DEF_LOAD_LAT  = 1;
    localparam int DEF_FLUSH_CYC = 1;
    localparam int DEF_CNT_W     = 16;

    // Sequence counter is wide enough for the largest legal LOAD_LAT (4).
    localparam int SEQ_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_FLUSH    = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_match.sv
// Source-operand comparator: flags when a producing stage writes a register
// that the ID instruction actually reads. Register 0 never creates a hazard.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int RW = DEF_RW
) (
    input  logic          i_wr_en,
    input  logic [RW-1:0] i_rd,
    input  logic          i_uses_rs,
    input  logic          i_uses_rt,
    input  logic [RW-1:0] i_rs,
    input  logic [RW-1:0] i_rt,
    output logic          o_match
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = i_uses_rs && (i_rd == i_rs);
    assign w_rt_hit = i_uses_rt && (i_rd == i_rt);
    assign o_match  = i_wr_en && (i_rd != '0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection for a 5-stage pipeline: load-use and branch-operand
// stalls, redirect flushes, and a saturating stalled-cycle counter.
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int RW        = DEF_RW,
    parameter int LOAD_LAT  = DEF_LOAD_LAT,
    parameter int FLUSH_CYC = DEF_FLUSH_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_src,
    input  logic             jmp,
    input  logic             branch_id,
    input  logic             uses_rs,
    input  logic             uses_rt,
    input  logic [RW-1:0]    rs_id,
    input  logic [RW-1:0]    rt_id,
    input  logic             reg_wr_ex,
    input  logic             mem_rd_ex,
    input  logic [RW-1:0]    rd_ex,
    input  logic             mem_rd_mem,
    input  logic [RW-1:0]    rd_mem,
    input  logic             clr_cnt,
    output logic             pc_write,
    output logic             ir_write,
    output logic             bubble,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    hazard_state_t    r_state;
    hazard_state_t    w_next_state;
    logic [SEQ_W-1:0] r_cnt;
    logic [SEQ_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_match_ex;
    logic             w_match_ld;
    logic             w_stall;
    logic             w_flush;

    hazard_match #(.RW(RW)) u_match_ex (
        .i_wr_en   (reg_wr_ex || mem_rd_ex),
        .i_rd      (rd_ex),
        .i_uses_rs (uses_rs),
        .i_uses_rt (uses_rt),
        .i_rs      (rs_id),
        .i_rt      (rt_id),
        .o_match   (w_match_ex)
    );

    hazard_match #(.RW(RW)) u_match_ld (
        .i_wr_en   (mem_rd_mem),
        .i_rd      (rd_mem),
        .i_uses_rs (uses_rs),
        .i_uses_rt (uses_rt),
        .i_rs      (rs_id),
        .i_rt      (rt_id),
        .o_match   (w_match_ld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Branch-operand stalls re-evaluate every cycle from RUN; only the
    // load-use and flush sequences occupy a multi-cycle state.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (branch_id && (w_match_ex || w_match_ld)) begin
                    w_stall = 1'b1;
                end else if (pc_src || jmp) begin
                    w_flush = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        w_next_state = ST_FLUSH;
                        w_next_cnt   = SEQ_W'(FLUSH_CYC - 1);
                    end
                end else if (mem_rd_ex && w_match_ex) begin
                    w_stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_next_state = ST_LD_STALL;
                        w_next_cnt   = SEQ_W'(LOAD_LAT - 1);
                    end
                end
            end
            ST_LD_STALL: begin
                w_stall    = 1'b1;
                w_next_cnt = r_cnt - SEQ_W'(1);
                if (r_cnt == SEQ_W'(1)) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_FLUSH: begin
                w_flush    = 1'b1;
                w_next_cnt = r_cnt - SEQ_W'(1);
                if (r_cnt == SEQ_W'(1)) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_RUN;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Reset looks like a stall so nothing advances while it is held.
    always_comb begin
        if (!rst) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            bubble   = 1'b1;
            flush    = 1'b0;
        end else begin
            pc_write = !w_stall;
            ir_write = !w_stall;
            bubble   = w_stall;
            flush    = w_flush;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
        end else if (!pc_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
